uart_tx_buffered: RTL and testbench

//  Buffered 8N1 UART transmitter. Accepts bytes from switches, text logic or the keyboard path, queues them in a FIFO,
//  and serialises them onto the board-to-board link (JA1) or RsTx.

---
 rtl/uart_tx_buffered_pkg.sv | 20 ++
 rtl/uart_tx_buffered_sync_fifo.sv | 63 ++++++
 rtl/uart_tx_buffered.sv | 130 +++++++++++++
 tb/tb_uart_tx_buffered.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding, frame constants
// and the baud divisor helper.
package uart_tx_buffered_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Clocks per bit; the fractional part is truncated.
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on rdata while not empty,
// so a pop and its data are consumed on the same clock edge.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign full  = (count_q == (AW + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are serialised back to back
// on tx, each bit held for CLK_HZ/BAUD clocks.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter  int CLK_HZ     = 100_000_000,
  parameter  int BAUD       = 9600,
  parameter  int FIFO_DEPTH = 16,
  localparam int DIV        = baud_div(CLK_HZ, BAUD),
  localparam int BW         = $clog2(DIV),
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          busy,
  output logic          tx
);

  tx_state_e     state_q;
  logic [BW-1:0] baud_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          busy_q;

  logic          fifo_empty;
  logic [7:0]    fifo_rdata;
  logic          baud_done;
  logic          pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (wr_en),
    .wdata (wr_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (fifo_empty),
    .count (count)
  );

  assign baud_done = (baud_cnt_q == BW'(DIV - 1));
  // The next frame is popped either from idle or on the last clock of a stop bit.
  assign pop       = !fifo_empty &&
                     ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_done));
  assign overflow  = wr_en && full;
  assign tx        = tx_q;
  assign busy      = busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q       <= 1'b1;
          busy_q     <= 1'b0;
          baud_cnt_q <= '0;
          if (!fifo_empty) begin
            shift_q   <= fifo_rdata;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            bit_idx_q <= '0;
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          if (baud_done) begin
            baud_cnt_q <= '0;
            tx_q       <= shift_q[0];
            state_q    <= ST_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + BW'(1);
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + BW'(1);
          end
        end
        ST_STOP: begin
          if (baud_done) begin
            baud_cnt_q <= '0;
            if (!fifo_empty) begin
              shift_q   <= fifo_rdata;
              tx_q      <= 1'b0;
              bit_idx_q <= '0;
              state_q   <= ST_START;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + BW'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at DIV=10: a line monitor decodes frames and
// each scenario task checks timing, data and FIFO status against hand-worked values.
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       busy;
  logic       tx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    int         start;
    logic       sb;
    logic       pb;
  } frame_t;

  frame_t rxq[$];

  uart_tx_buffered #(
    .CLK_HZ     (100_000_000),
    .BAUD       (10_000_000),
    .FIFO_DEPTH (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .busy     (busy),
    .tx       (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: start detected at the negedge after the edge that drove tx low;
  // samples mid-bit; frames overlapping a reset are discarded.
  initial begin
    frame_t f;
    bit     ok;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        f.start = cyc;
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin @(negedge clk); if (reset !== 1'b1) ok = 1'b0; end
        f.sb = tx;
        for (int b = 0; b < 8; b++) begin
          for (int k = 0; k < 10; k++) begin @(negedge clk); if (reset !== 1'b1) ok = 1'b0; end
          f.data[b] = tx;
        end
        for (int k = 0; k < 10; k++) begin @(negedge clk); if (reset !== 1'b1) ok = 1'b0; end
        f.pb = tx;
        if (ok) rxq.push_back(f);
      end
    end
  end

  task automatic wait_frames(input int n, input int limit);
    for (int i = 0; i < limit && rxq.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", overflow); end
    reset = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || count !== 5'd0) begin
        errors++;
        $display("FAIL idle_after_rst cycle %0d: got tx=%b busy=%b count=%0d expected tx=1 busy=0 count=0",
                 i, tx, busy, count);
      end
    end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_single();
    int n;
    rxq.delete();
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h41; n = cyc + 1;
    @(negedge clk); wr_en = 1'b0;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_pre_tx: got %b expected 1", tx); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_pre_count: got %0d expected 1", count); end
    @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL single_start_tx: got %b expected 0", tx); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_start_busy: got %b expected 1", busy); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_start_count: got %0d expected 0", count); end
    repeat (9) @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL single_start_end: got %b expected 0", tx); end
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_bit0: got %b expected 1", tx); end
    while (cyc < n + 100) @(negedge clk);
    checks++; if (busy !== 1'b1 || tx !== 1'b1) begin errors++; $display("FAIL single_stop_end: got busy=%b tx=%b expected busy=1 tx=1", busy, tx); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
    wait_frames(1, 200);
    checks++; if (rxq.size() != 1) begin errors++; $display("FAIL single_nframes: got %0d expected 1", rxq.size()); end
    for (int i = 0; i < rxq.size() && i < 1; i++) begin
      checks++; if (rxq[i].data !== 8'h41) begin errors++; $display("FAIL single_data: got %h expected 41", rxq[i].data); end
      checks++; if (rxq[i].start != n + 1) begin errors++; $display("FAIL single_latency: got %0d expected %0d", rxq[i].start, n + 1); end
      checks++; if (rxq[i].sb !== 1'b0 || rxq[i].pb !== 1'b1) begin errors++; $display("FAIL single_framing: got start=%b stop=%b expected 0/1", rxq[i].sb, rxq[i].pb); end
    end
    $display("test_single done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_burst();
    logic [7:0] bytes [3] = '{8'h48, 8'h49, 8'h0A};
    int n;
    rxq.delete();
    @(negedge clk); n = cyc + 1;
    for (int k = 0; k < 3; k++) begin wr_en = 1'b1; wr_data = bytes[k]; @(negedge clk); end
    wr_en = 1'b0;
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL burst_peak_count: got %0d expected 2", count); end
    wait_frames(3, 400);
    checks++; if (rxq.size() != 3) begin errors++; $display("FAIL burst_nframes: got %0d expected 3", rxq.size()); end
    for (int i = 0; i < rxq.size() && i < 3; i++) begin
      checks++; if (rxq[i].data !== bytes[i]) begin errors++; $display("FAIL burst_data[%0d]: got %h expected %h", i, rxq[i].data, bytes[i]); end
      checks++; if (rxq[i].start != n + 1 + 100 * i) begin errors++; $display("FAIL burst_start[%0d]: got %0d expected %0d", i, rxq[i].start, n + 1 + 100 * i); end
    end
    while (cyc < n + 300) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL burst_busy_last: got %b expected 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_busy_fall: got %b expected 0", busy); end
    $display("test_burst done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_overflow();
    int n;
    rxq.delete();
    @(negedge clk); n = cyc + 1;
    for (int k = 0; k < 17; k++) begin wr_en = 1'b1; wr_data = 8'h10 + 8'(k); @(negedge clk); end
    wr_data = 8'hFF;
    #1;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count_full: got %0d expected 16", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b expected 1", overflow); end
    @(negedge clk); wr_en = 1'b0;
    #1;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count_after: got %0d expected 16", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end: got %b expected 0", overflow); end
    wait_frames(17, 1900);
    checks++; if (rxq.size() != 17) begin errors++; $display("FAIL ovf_nframes: got %0d expected 17", rxq.size()); end
    for (int i = 0; i < rxq.size() && i < 17; i++) begin
      checks++; if (rxq[i].data !== 8'h10 + 8'(i)) begin errors++; $display("FAIL ovf_data[%0d]: got %h expected %h", i, rxq[i].data, 8'h10 + 8'(i)); end
      checks++; if (rxq[i].start != n + 1 + 100 * i) begin errors++; $display("FAIL ovf_start[%0d]: got %0d expected %0d", i, rxq[i].start, n + 1 + 100 * i); end
    end
    repeat (150) @(negedge clk);
    checks++; if (rxq.size() != 17) begin errors++; $display("FAIL ovf_dropped: got %0d frames expected 17", rxq.size()); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL ovf_drained: got %0d expected 0", count); end
    $display("test_overflow done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_push_pop();
    int n;
    rxq.delete();
    @(negedge clk); n = cyc + 1;
    for (int k = 0; k < 6; k++) begin wr_en = 1'b1; wr_data = 8'hA0 + 8'(k); @(negedge clk); end
    wr_en = 1'b0;
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL pp_count_pre: got %0d expected 5", count); end
    while (cyc < n + 100) @(negedge clk);
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL pp_count_before: got %0d expected 5", count); end
    wr_en = 1'b1; wr_data = 8'hA6;
    @(negedge clk); wr_en = 1'b0;
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL pp_count_same: got %0d expected 5", count); end
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL pp_next_start: got %b expected 0", tx); end
    wait_frames(7, 800);
    checks++; if (rxq.size() != 7) begin errors++; $display("FAIL pp_nframes: got %0d expected 7", rxq.size()); end
    for (int i = 0; i < rxq.size() && i < 7; i++) begin
      checks++; if (rxq[i].data !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL pp_data[%0d]: got %h expected %h", i, rxq[i].data, 8'hA0 + 8'(i)); end
      checks++; if (rxq[i].start != n + 1 + 100 * i) begin errors++; $display("FAIL pp_start[%0d]: got %0d expected %0d", i, rxq[i].start, n + 1 + 100 * i); end
    end
    $display("test_push_pop done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reset_mid();
    logic [7:0] bytes [3] = '{8'h55, 8'h33, 8'h22};
    int n;
    int n2;
    rxq.delete();
    @(negedge clk); n = cyc + 1;
    for (int k = 0; k < 3; k++) begin wr_en = 1'b1; wr_data = bytes[k]; @(negedge clk); end
    wr_en = 1'b0;
    while (cyc < n + 30) @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_bit1: got %b expected 0", tx); end
    #2 reset = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_async_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_async_busy: got %b expected 0", busy); end
    checks++; if (count !== 5'd0 || full !== 1'b0) begin errors++; $display("FAIL mid_async_fifo: got count=%0d full=%b expected 0/0", count, full); end
    repeat (20) @(negedge clk);
    reset = 1'b1;
    repeat (150) @(negedge clk);
    checks++; if (rxq.size() != 0) begin errors++; $display("FAIL mid_no_resume: got %0d frames expected 0", rxq.size()); end
    checks++; if (tx !== 1'b1 || busy !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL mid_idle: got tx=%b busy=%b count=%0d expected 1/0/0", tx, busy, count); end
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h0F; n2 = cyc + 1;
    @(negedge clk); wr_en = 1'b0;
    wait_frames(1, 200);
    checks++; if (rxq.size() != 1) begin errors++; $display("FAIL mid_nframes: got %0d expected 1", rxq.size()); end
    for (int i = 0; i < rxq.size() && i < 1; i++) begin
      checks++; if (rxq[i].data !== 8'h0F) begin errors++; $display("FAIL mid_data: got %h expected 0f", rxq[i].data); end
      checks++; if (rxq[i].start != n2 + 1) begin errors++; $display("FAIL mid_latency: got %0d expected %0d", rxq[i].start, n2 + 1); end
      checks++; if (rxq[i].sb !== 1'b0 || rxq[i].pb !== 1'b1) begin errors++; $display("FAIL mid_framing: got start=%b stop=%b expected 0/1", rxq[i].sb, rxq[i].pb); end
    end
    $display("test_reset_mid done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_push_pop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
